// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit and the instruction memory.
// The request and response channels are grouped so the fetch stage takes one bus port.
// The master modport is the fetch unit side and the slave modport is the memory side.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 64
);
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage that feeds main_decoder.
// It owns the fetch PC and issues in-order word requests.
// The request credit is count + outstanding < QUEUE_DEPTH, so a returning word always has
// a free queue slot.
// On a redirect the unit flushes the prefetch queue and drops the responses still in flight.
//
// Optional feature: define FETCH_BYPASS_EN to forward a kept response combinationally to the
// decoder when the queue is empty. This gives 0-cycle response-to-decode latency.
// Without the macro, every word passes through the queue.
module instr_fetch_unit #(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                QUEUE_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  input  logic                stall,
  output logic                instr_valid,
  output logic [31:0]         instruction,
  output logic [ADDR_W-1:0]   instr_pc
);
  localparam int          PW          = $clog2(QUEUE_DEPTH);
  localparam int          CW          = PW + 1;
  localparam int          CW1         = CW + 1;
  localparam logic [CW:0] DEPTH_LIMIT = CW1'(QUEUE_DEPTH);
  localparam logic [31:0] NOP         = 32'h00000013;

  logic [ADDR_W-1:0] fetch_pc_reg;
  logic [ADDR_W-1:0] resp_pc_reg;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     outstanding_reg;
  logic [CW-1:0]     discard_reg;
  logic [PW-1:0]     head_reg;
  logic [PW-1:0]     tail_reg;

  logic [31:0]       q_data [QUEUE_DEPTH];
  logic [ADDR_W-1:0] q_pc   [QUEUE_DEPTH];

  logic [ADDR_W-1:0] redirect_target;
  logic [CW:0]       in_flight;
  logic              req_fire;
  logic              resp_accept;
  logic              resp_keep;
  logic              queue_nonempty;
  logic              bypass;
  logic              push;
  logic              pop;
  logic              redirect_pc_unused;

  // Instructions are word aligned, so the low bits of a redirect target are discarded.
  assign redirect_target    = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign redirect_pc_unused = ^redirect_pc[1:0];

  assign in_flight           = CW1'(count_reg) + CW1'(outstanding_reg);
  assign imem.imem_req_valid = !rst && !redirect_valid && (in_flight < DEPTH_LIMIT);
  assign imem.imem_req_addr  = fetch_pc_reg;
  assign req_fire            = imem.imem_req_valid && imem.imem_req_ready;

  // A response that arrives with nothing outstanding is spurious and is ignored.
  // A response that arrives while discard is nonzero belongs to a fetch stream that a
  // redirect has killed, so it is dropped.
  assign resp_accept    = imem.imem_resp_valid && (outstanding_reg != '0);
  assign resp_keep      = resp_accept && (discard_reg == '0) && !redirect_valid;
  assign queue_nonempty = (count_reg != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = resp_keep && !queue_nonempty;
`else
  assign bypass = 1'b0;
`endif

  // When a bypassed word is consumed in its arrival cycle, it never occupies a queue slot.
  assign push = resp_keep && !(bypass && !stall);
  assign pop  = queue_nonempty && !stall && !redirect_valid;

  // Each queue slot captures the kept response when the tail points at that slot.
  generate
    for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
      logic [31:0]       data_reg;
      logic [ADDR_W-1:0] pc_reg;

      // Write this slot on a push addressed to it.
      always_ff @(posedge clk) begin
        if (push && (tail_reg == PW'(gi))) begin
          data_reg <= imem.imem_resp_data;
          pc_reg   <= resp_pc_reg;
        end
      end

      assign q_data[gi] = data_reg;
      assign q_pc[gi]   = pc_reg;
    end
  endgenerate

  // Fetch/response PCs, credit counters and queue pointers.
  // A redirect overrides everything except rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
    end else if (redirect_valid) begin
      fetch_pc_reg    <= redirect_target;
      resp_pc_reg     <= redirect_target;
      count_reg       <= '0;
      head_reg        <= '0;
      tail_reg        <= '0;
      // Every request still in flight after this cycle returns a stale word.
      outstanding_reg <= outstanding_reg - CW'(resp_accept);
      discard_reg     <= outstanding_reg - CW'(resp_accept);
    end else begin
      if (req_fire) begin
        fetch_pc_reg <= fetch_pc_reg + ADDR_W'(4);
      end
      if (resp_keep) begin
        resp_pc_reg <= resp_pc_reg + ADDR_W'(4);
      end
      if (resp_accept && (discard_reg != '0)) begin
        discard_reg <= discard_reg - CW'(1);
      end
      outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(resp_accept);
      if (push) begin
        tail_reg <= tail_reg + PW'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PW'(1);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  // Decoder-facing outputs: the queue head, or the bypassed word, or a NOP when empty.
  always_comb begin
    instr_valid = 1'b0;
    instruction = NOP;
    instr_pc    = resp_pc_reg;
    if (rst) begin
      instr_pc = RESET_PC;
    end else if (queue_nonempty) begin
      instr_valid = 1'b1;
      instruction = q_data[head_reg];
      instr_pc    = q_pc[head_reg];
    end else if (bypass) begin
      instr_valid = 1'b1;
      instruction = imem.imem_resp_data;
      instr_pc    = resp_pc_reg;
    end
  end
endmodule
